// File: rtl/counter_driver_pkg.sv
// Shared types and constants for the counter driver.
package counter_driver_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StReport
    } state_e;

    localparam int unsigned CLEAR_CYCLES = 2;

endpackage

// File: rtl/counter_driver_timer.sv
// Saturating RUN-cycle counter with synchronous clear and a limit-reached flag.
module counter_driver_timer #(
    parameter int unsigned CYC_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CYC_WIDTH-1:0] count,
    output logic                 limit_reached
);

    localparam logic [CYC_WIDTH-1:0] Limit    = CYC_WIDTH'(TIMEOUT);
    localparam logic [CYC_WIDTH-1:0] CountMax = '1;

    logic [CYC_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CountMax)) begin
            count_d = count_q + CYC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count         = count_q;
    assign limit_reached = (count_q >= Limit);

endmodule

// File: rtl/counter_driver.sv
// Drives a counter under test: clears it, runs it until done or timeout, reports the cycle count.
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int unsigned STOP_WIDTH = 4,
    parameter int unsigned CYC_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [STOP_WIDTH-1:0] req_stop,
    output logic                  ctr_reset_l,
    output logic [STOP_WIDTH-1:0] ctr_stop,
    input  logic                  ctr_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CYC_WIDTH-1:0]  rsp_cycles,
    output logic                  rsp_timeout,
    output logic                  rsp_match
);

    localparam int unsigned ClrW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_CYCLES - 1);

    state_e                state_q, state_d;
    logic [ClrW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [STOP_WIDTH-1:0] stop_q, stop_d;
    logic [CYC_WIDTH-1:0]  cycles_q, cycles_d;
    logic                  timeout_q, timeout_d;
    logic                  match_q, match_d;

    logic                  timer_clear;
    logic                  timer_en;
    logic [CYC_WIDTH-1:0]  count;
    logic                  limit_reached;

    counter_driver_timer #(
        .CYC_WIDTH (CYC_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .clear         (timer_clear),
        .enable        (timer_en),
        .count         (count),
        .limit_reached (limit_reached)
    );

    // Gated by reset so no request is accepted while the driver is being reset.
    assign req_ready   = (state_q == StIdle) && !reset;
    assign ctr_reset_l = (state_q == StRun);
    assign rsp_valid   = (state_q == StReport);
    assign ctr_stop    = stop_q;
    assign rsp_cycles  = cycles_q;
    assign rsp_timeout = timeout_q;
    assign rsp_match   = match_q;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        stop_d      = stop_q;
        cycles_d    = cycles_q;
        timeout_d   = timeout_q;
        match_d     = match_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            StIdle: begin
                clr_cnt_d = '0;
                if (req_valid && req_ready) begin
                    stop_d  = req_stop;
                    state_d = StClear;
                end
            end
            StClear: begin
                timer_clear = 1'b1;
                if (clr_cnt_q == ClrLast) begin
                    state_d = StRun;
                end else begin
                    clr_cnt_d = clr_cnt_q + ClrW'(1);
                end
            end
            StRun: begin
                // Done wins over timeout when both land in the same cycle.
                if (ctr_done) begin
                    cycles_d  = count;
                    timeout_d = 1'b0;
                    match_d   = (count == CYC_WIDTH'(stop_q));
                    state_d   = StReport;
                end else if (limit_reached) begin
                    cycles_d  = CYC_WIDTH'(TIMEOUT);
                    timeout_d = 1'b1;
                    match_d   = 1'b0;
                    state_d   = StReport;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StReport: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
            stop_q    <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            stop_q    <= stop_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            match_q   <= match_d;
        end
    end

endmodule

// File: tb/tb_counter_driver.sv
// Bench for counter_driver: vector table plus hand sequences, responses checked via scoreboard.
module tb_counter_driver;

    localparam int unsigned SW = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_stop = '0;
    logic          ctr_reset_l;
    logic [SW-1:0] ctr_stop;
    logic          ctr_done;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [CW-1:0] rsp_cycles;
    logic          rsp_timeout;
    logic          rsp_match;

    counter_driver #(
        .STOP_WIDTH (SW),
        .CYC_WIDTH  (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_stop    (req_stop),
        .ctr_reset_l (ctr_reset_l),
        .ctr_stop    (ctr_stop),
        .ctr_done    (ctr_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_cycles  (rsp_cycles),
        .rsp_timeout (rsp_timeout),
        .rsp_match   (rsp_match)
    );

    always #5 clk = ~clk;

    // Counter-under-test model: counts while out of reset; done_at < 0 means done at ctr_stop.
    int mcnt = 0;
    int done_at = -1;
    bit force_clr = 1'b0;
    always @(posedge clk) begin
        if (!ctr_reset_l) mcnt <= 0;
        else              mcnt <= mcnt + 1;
    end
    assign ctr_done = (ctr_reset_l && ((done_at < 0) ? (mcnt == int'(ctr_stop)) : (mcnt == done_at)))
                      || (force_clr && !ctr_reset_l);

    typedef struct {
        logic [CW-1:0] cycles;
        logic          to;
        logic          match;
    } exp_t;

    typedef struct {
        logic [SW-1:0] stop;
        int            done_at;
        bit            force_clr;
        exp_t          e;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: samples after stimulus settles at the negedge.
    always begin
        @(negedge clk);
        #2;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_cycles), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_cycles", 32'(rsp_cycles), 32'(e.cycles));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                check("rsp_match", 32'(rsp_match), 32'(e.match));
            end
        end
    end

    // Call at a negedge; returns at the negedge where rsp_valid is first seen.
    task automatic do_req(input logic [SW-1:0] stop, input exp_t e, output int lat);
        int guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_stop  = stop;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        check("ctr_stop_latched", 32'(ctr_stop), 32'(stop));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        logic [CW-1:0] rc;
        logic rt, rm;

        //                stop  done_at force   cycles     to    match
        vecs[0] = '{4'd5,  -1,   1'b0, '{16'd5,  1'b0, 1'b1}};
        vecs[1] = '{4'd0,  -1,   1'b1, '{16'd0,  1'b0, 1'b1}};
        vecs[2] = '{4'd15, -1,   1'b1, '{16'd15, 1'b0, 1'b1}};
        vecs[3] = '{4'd4,  6,    1'b0, '{16'd6,  1'b0, 1'b0}};
        vecs[4] = '{4'd0,  1000, 1'b0, '{16'd64, 1'b1, 1'b0}};
        vecs[5] = '{4'd4,  64,   1'b0, '{16'd64, 1'b0, 1'b0}};
        vecs[6] = '{4'd9,  63,   1'b1, '{16'd63, 1'b0, 1'b0}};
        vecs[7] = '{4'd3,  1000, 1'b1, '{16'd64, 1'b1, 1'b0}};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_ctr_reset_l", 32'(ctr_reset_l), 32'd0);
        check("rst_ctr_stop", 32'(ctr_stop), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_rsp_match", 32'(rsp_match), 32'd0);
        reset = 1'b0;
        #1;
        check("req_ready_after_rst", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            done_at   = vecs[i].done_at;
            force_clr = vecs[i].force_clr;
            do_req(vecs[i].stop, vecs[i].e, lat);
            check("latency", 32'(lat), 32'(3 + int'(vecs[i].e.cycles)));
            @(negedge clk);
            check("idle_after_rsp", 32'({rsp_valid, req_ready}), 32'b01);
            check("rsp_cycles_held", 32'(rsp_cycles), 32'(vecs[i].e.cycles));
            check("rsp_timeout_held", 32'(rsp_timeout), 32'(vecs[i].e.to));
        end
        done_at   = -1;
        force_clr = 1'b0;

        // Backpressure: hold rsp_ready low for 10 cycles in REPORT
        rsp_ready = 1'b0;
        do_req(4'd5, '{16'd5, 1'b0, 1'b1}, lat);
        check("bp_latency", 32'(lat), 32'd8);
        rc = rsp_cycles;
        rt = rsp_timeout;
        rm = rsp_match;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({rsp_valid, req_ready, rt, rm, rc}),
                  32'({1'b1, 1'b0, 1'b0, 1'b1, 16'd5}));
            check("bp_outputs", 32'({rsp_valid, req_ready, rsp_timeout, rsp_match, rsp_cycles}),
                  32'({1'b1, 1'b0, rt, rm, rc}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'({rsp_valid, req_ready}), 32'b01);

        // Reset during RUN at count 3, then a fresh request
        req_valid = 1'b1;
        req_stop  = 4'd15;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("run_count3", 32'({ctr_reset_l, 28'(mcnt)}), 32'({1'b1, 28'd3}));
        reset = 1'b1;
        #1;
        check("req_ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("abort_ctr_reset_l", 32'(ctr_reset_l), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_cycles", 32'(rsp_cycles), 32'd0);
        check("abort_ctr_stop", 32'(ctr_stop), 32'd0);
        reset = 1'b0;
        #1;
        check("req_ready_post_abort", 32'(req_ready), 32'd1);
        @(negedge clk);
        do_req(4'd15, '{16'd15, 1'b0, 1'b1}, lat);
        check("post_abort_latency", 32'(lat), 32'd18);
        @(negedge clk);

        // Back-to-back requests with req_valid held high
        req_valid = 1'b1;
        req_stop  = 4'd2;
        sb.push_back('{16'd2, 1'b0, 1'b1});
        sb.push_back('{16'd7, 1'b0, 1'b1});
        @(negedge clk);
        req_stop = 4'd7;
        check("b2b_stop1", 32'(ctr_stop), 32'd2);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency1", 32'(lat), 32'd5);
        @(negedge clk);
        check("b2b_idle_one_cycle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_accept", 32'({req_ready, 4'(ctr_stop)}), 32'({1'b0, 4'd7}));
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency2", 32'(lat), 32'd10);
        @(negedge clk);
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_driver.md
COUNTER_DRIVER -- requirements
Module: counter_driver

Interface
REQ-001 SHALL have parameter STOP_WIDTH, default 4, width of the stop value.
REQ-002 SHALL have parameter CYC_WIDTH, default 16, width of the measured cycle count.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum RUN cycles before abort; legal range 1 to 2**CYC_WIDTH-1.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  driver can accept a request.
REQ-008 req_stop  input  STOP_WIDTH  stop value to program into the counter.
REQ-009 ctr_reset_l  output  1  active-low reset driven to the counter under test.
REQ-010 ctr_stop  output  STOP_WIDTH  stop value driven to the counter under test.
REQ-011 ctr_done  input  1  done from the counter under test.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  result consumer ready.
REQ-014 rsp_cycles  output  CYC_WIDTH  RUN cycles counted until done was seen.
REQ-015 rsp_timeout  output  1  done never seen within TIMEOUT cycles.
REQ-016 rsp_match  output  1  rsp_cycles equals zero-extended latched stop and rsp_timeout is 0.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, RUN, REPORT.
REQ-018 IDLE: req_ready=1, ctr_reset_l=0; req_valid&&req_ready latches req_stop into ctr_stop and moves to CLEAR next cycle.
REQ-019 req_ready SHALL be 0 in every state except IDLE.
REQ-020 CLEAR: ctr_reset_l=0 for exactly 2 cycles, then RUN; cycle counter cleared to 0.
REQ-021 RUN: ctr_reset_l=1; ctr_done sampled every cycle; cycle counter increments after each RUN cycle where done is 0.
REQ-022 ctr_done high in a RUN cycle SHALL capture the current count into rsp_cycles, rsp_timeout=0, and move to REPORT; first RUN cycle has count 0.
REQ-023 ctr_done SHALL be ignored in IDLE, CLEAR and REPORT.
REQ-024 Count reaching TIMEOUT with done still 0 SHALL move to REPORT with rsp_cycles=TIMEOUT, rsp_timeout=1.
REQ-025 Cycle counter SHALL saturate at 2**CYC_WIDTH-1, never wrap.
REQ-026 REPORT: rsp_valid=1, ctr_reset_l=0, rsp_* held stable until rsp_valid&&rsp_ready; then IDLE next cycle.
REQ-027 rsp_cycles, rsp_timeout, rsp_match SHALL be registered and hold their last values outside REPORT.
REQ-028 ctr_stop SHALL stay at the latched value from acceptance until the next acceptance.
REQ-029 Latency: request accept to rsp_valid SHALL be 3+N cycles, where N is the count at done, or TIMEOUT on timeout.

Reset
REQ-030 reset high SHALL force IDLE on the next edge and abandon any operation in progress without a response.
REQ-031 Reset values SHALL be: ctr_reset_l=0, ctr_stop=0, rsp_valid=0, rsp_cycles=0, rsp_timeout=0, rsp_match=0, cycle counter=0.
REQ-032 req_ready SHALL be 0 while reset is high and 1 in the first cycle after reset is released.

Structure
REQ-033 Package counter_driver_pkg SHALL hold the state enum and constant CLEAR_CYCLES=2.
REQ-034 Sub-module counter_driver_timer SHALL hold the saturating cycle counter with clear, enable and limit-reached outputs.
REQ-035 Implementation SHALL be 120-400 lines of RTL across both modules.

Verification
REQ-036 Reference counter model, stop=5, rsp_ready=1 -> rsp_cycles=5, rsp_match=1, rsp_timeout=0, rsp_valid 8 cycles after accept.
REQ-037 stop=0 -> rsp_cycles=0, rsp_match=1; done high during CLEAR produces no early exit.
REQ-038 ctr_done tied 0, TIMEOUT=64 -> rsp_timeout=1, rsp_cycles=64, rsp_match=0.
REQ-039 rsp_ready held 0 for 10 cycles in REPORT -> rsp_* stable and req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-040 reset asserted in RUN at count 3 -> IDLE next cycle, ctr_reset_l=0, no rsp_valid pulse; next request with stop=15 -> rsp_cycles=15.
REQ-041 Back-to-back requests stop=2 then stop=7, req_valid held high -> second accept exactly one cycle after first response handshake; responses 2 then 7.
